// File: rtl/alu_result_tx_seq.sv
// Sends a latched ALU result to the UART TX as uppercase hex text plus a terminator.
// Optional CR before the terminator: define ALU_TX_CRLF_EN.
module alu_result_tx_seq #(
   parameter int unsigned NIBBLES        = 8,
   parameter logic [7:0]  TERM_CHAR      = 8'h0A,
   parameter bit          SUPPRESS_ZEROS = 1'b1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [4*NIBBLES-1:0] result,
   input  logic                 tx_done,
   output logic                 tx_start,
   output logic [7:0]           tx_data,
   output logic                 busy,
   output logic                 done
);

   localparam int unsigned W  = 4 * NIBBLES;
   localparam int unsigned CW = $clog2(NIBBLES + 1);
   localparam logic [CW-1:0] CNT_INIT = CW'(NIBBLES);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   typedef enum logic [3:0] {
      S_IDLE,
      S_SKIP,
      S_SEND,
      S_WAIT,
`ifdef ALU_TX_CRLF_EN
      S_CR,
      S_CRWAIT,
`endif
      S_TERM,
      S_TWAIT,
      S_DONE
   } state_e;

   state_e        state_q, state_d;
   logic [W-1:0]  sh_q, sh_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          txd_q;
   logic          tx_start_q, tx_start_d;
   logic [7:0]    tx_data_q, tx_data_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;

   logic          txd_edge;
   logic [3:0]    top;
   logic [W-1:0]  sh_shift;
   logic [CW-1:0] cnt_dec;

   function automatic logic [7:0] hex_ascii(input logic [3:0] n);
      return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
   endfunction

   assign txd_edge = tx_done & ~txd_q;
   assign top      = sh_q[W-1 -: 4];
   assign sh_shift = {sh_q[W-5:0], 4'h0};
   assign cnt_dec  = cnt_q - CNT_ONE;

   always_comb begin
      state_d    = state_q;
      sh_d       = sh_q;
      cnt_d      = cnt_q;
      tx_start_d = 1'b0;
      tx_data_d  = tx_data_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            busy_d = 1'b0;
            if (start) begin
               sh_d    = result;
               cnt_d   = CNT_INIT;
               busy_d  = 1'b1;
               state_d = SUPPRESS_ZEROS ? S_SKIP : S_SEND;
            end
         end
         S_SKIP: begin
            // the last digit is always sent, even when zero
            if (top == 4'h0 && cnt_q > CNT_ONE) begin
               sh_d  = sh_shift;
               cnt_d = cnt_dec;
            end else begin
               state_d = S_SEND;
            end
         end
         S_SEND: begin
            tx_data_d  = hex_ascii(top);
            tx_start_d = 1'b1;
            state_d    = S_WAIT;
         end
         S_WAIT: begin
            if (txd_edge) begin
               sh_d  = sh_shift;
               cnt_d = cnt_dec;
               if (cnt_dec == '0) begin
`ifdef ALU_TX_CRLF_EN
                  state_d = S_CR;
`else
                  state_d = S_TERM;
`endif
               end else begin
                  state_d = S_SEND;
               end
            end
         end
`ifdef ALU_TX_CRLF_EN
         S_CR: begin
            tx_data_d  = 8'h0D;
            tx_start_d = 1'b1;
            state_d    = S_CRWAIT;
         end
         S_CRWAIT: begin
            if (txd_edge) state_d = S_TERM;
         end
`endif
         S_TERM: begin
            tx_data_d  = TERM_CHAR;
            tx_start_d = 1'b1;
            state_d    = S_TWAIT;
         end
         S_TWAIT: begin
            if (txd_edge) begin
               done_d  = 1'b1;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         sh_q       <= '0;
         cnt_q      <= '0;
         txd_q      <= 1'b0;
         tx_start_q <= 1'b0;
         tx_data_q  <= 8'h00;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         sh_q       <= sh_d;
         cnt_q      <= cnt_d;
         txd_q      <= tx_done;
         tx_start_q <= tx_start_d;
         tx_data_q  <= tx_data_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign tx_start = tx_start_q;
   assign tx_data  = tx_data_q;
   assign busy     = busy_q;
   assign done     = done_q;

endmodule

// File: tb/tb_alu_result_tx_seq.sv
// Directed bench for alu_result_tx_seq with a simple UART TX responder.
// Expected byte lists include a CR when ALU_TX_CRLF_EN is defined.
module tb_alu_result_tx_seq;

   typedef logic [7:0] bq_t[$];

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        start;
   logic [31:0] result;
   logic        sel;
   logic        manual;
   logic        man_done;

   logic        ts1, ts2, bu1, bu2, dn1, dn2, txd1, txd2;
   logic [7:0]  td1, td2;
   logic        st1, st2;

   logic        obs_tx_start, obs_busy, obs_done, obs_tx_done;
   logic [7:0]  obs_tx_data;
   logic        mdl_done, txd_src;
   int          ph;

   assign st1          = start & ~sel;
   assign st2          = start & sel;
   assign obs_tx_start = sel ? ts2 : ts1;
   assign obs_tx_data  = sel ? td2 : td1;
   assign obs_busy     = sel ? bu2 : bu1;
   assign obs_done     = sel ? dn2 : dn1;
   assign txd_src      = manual ? man_done : mdl_done;
   assign txd1         = sel ? 1'b0 : txd_src;
   assign txd2         = sel ? txd_src : 1'b0;
   assign obs_tx_done  = sel ? txd2 : txd1;

   alu_result_tx_seq u_dut (
      .clk(clk), .reset(rst_n), .start(st1), .result(result),
      .tx_done(txd1), .tx_start(ts1), .tx_data(td1),
      .busy(bu1), .done(dn1)
   );

   alu_result_tx_seq #(.SUPPRESS_ZEROS(1'b0)) u_nz (
      .clk(clk), .reset(rst_n), .start(st2), .result(result),
      .tx_done(txd2), .tx_start(ts2), .tx_data(td2),
      .busy(bu2), .done(dn2)
   );

   // tx_done rises ~10 cycles after tx_start and stays high 3 cycles
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ph       <= 0;
         mdl_done <= 1'b0;
      end else begin
         if (obs_tx_start)            ph <= 1;
         else if (ph != 0 && ph < 15) ph <= ph + 1;
         else                         ph <= 0;
         mdl_done <= (ph >= 9 && ph <= 11);
      end
   end

   int   vectors = 0;
   int   errs = 0;
   int   ndone = 0;
   bq_t  got;
   logic prev_td = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] expv);
      vectors++;
      assert (obs === expv) else begin
         errs++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   always @(negedge clk) begin
      if (obs_tx_done && !prev_td && got.size() > 0)
         chk("data_stable", {24'h0, obs_tx_data}, {24'h0, got[$]});
      prev_td <= obs_tx_done;
      if (obs_tx_start) got.push_back(obs_tx_data);
      if (obs_done) ndone <= ndone + 1;
   end

   function automatic bq_t wt(input bq_t d);
      bq_t r = d;
`ifdef ALU_TX_CRLF_EN
      r.push_back(8'h0D);
`endif
      r.push_back(8'h0A);
      return r;
   endfunction

   task automatic kick(input logic [31:0] v, input int explat,
                       output int base, output int dbase);
      int k;
      base   = got.size();
      dbase  = ndone;
      result = v;
      start  = 1'b1;
      k      = 0;
      do begin
         @(negedge clk);
         start = 1'b0;
         k++;
      end while (!obs_tx_start && k < 200);
      chk("latency", k - 1, explat);
      chk("busy_up", obs_busy, 1);
   endtask

   task automatic finish_chk(input bq_t e, input int base, input int dbase);
      int k;
      logic [31:0] ob;
      k = 0;
      while (obs_done !== 1'b1 && k < 3000) begin
         @(negedge clk);
         k++;
      end
      chk("done_seen", obs_done, 1);
      chk("busy_at_done", obs_busy, 1);
      @(negedge clk);
      chk("busy_fall", obs_busy, 0);
      chk("done_1cyc", obs_done, 0);
      repeat (4) @(negedge clk);
      chk("ndone", ndone - dbase, 1);
      chk("nbytes", got.size() - base, e.size());
      for (int i = 0; i < e.size(); i++) begin
         ob = (base + i < got.size()) ? {24'h0, got[base+i]} : 32'hDEAD;
         chk($sformatf("byte%0d", i), ob, {24'h0, e[i]});
      end
   endtask

   initial begin
      int b, d, k, n;
      bq_t e;
      rst_n    = 1'b0;
      start    = 1'b0;
      result   = 32'h0;
      sel      = 1'b0;
      manual   = 1'b0;
      man_done = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_tx_start", obs_tx_start, 0);
      chk("rst_tx_data", obs_tx_data, 0);
      chk("rst_busy", obs_busy, 0);
      chk("rst_done", obs_done, 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      e = '{8'h31, 8'h46};
      kick(32'h0000001F, 8, b, d);
      finish_chk(wt(e), b, d);

      e = '{8'h30};
      kick(32'h00000000, 9, b, d);
      finish_chk(wt(e), b, d);

      sel = 1'b1;
      repeat (2) @(negedge clk);
      e = '{8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30};
      kick(32'h00000000, 1, b, d);
      finish_chk(wt(e), b, d);
      sel = 1'b0;
      repeat (2) @(negedge clk);

      e = '{8'h44, 8'h45, 8'h41, 8'h44, 8'h42, 8'h45, 8'h45, 8'h46};
      kick(32'hDEADBEEF, 2, b, d);
      finish_chk(wt(e), b, d);

      manual = 1'b1;
      e = wt('{8'h31, 8'h32});
      n = e.size();
      kick(32'h00000012, 8, b, d);
      @(negedge clk);
      result = 32'hFF;
      start  = 1'b1;
      @(negedge clk);
      start  = 1'b0;
      result = 32'hFFFFFFFF;
      for (int i = 0; i < n; i++) begin
         k = 0;
         while (got.size() - b <= i && k < 200) begin
            @(negedge clk);
            k++;
         end
         repeat (10) @(negedge clk);
         man_done = 1'b1;
         if (i < n - 1) begin
            repeat (20) @(negedge clk);
            man_done = 1'b0;
         end
      end
      finish_chk(e, b, d);
      man_done = 1'b0;
      manual   = 1'b0;
      repeat (20) @(negedge clk);

      kick(32'h0000ABCD, 6, b, d);
      k = 0;
      while (got.size() - b < 2 && k < 300) begin
         @(negedge clk);
         k++;
      end
      chk("abort_reach_b2", got.size() - b, 2);
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("abort_tx_start", obs_tx_start, 0);
      chk("abort_busy", obs_busy, 0);
      chk("abort_done", obs_done, 0);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      chk("abort_nbytes", got.size() - b, 2);
      chk("abort_ndone", ndone - d, 0);
      e = '{8'h37};
      kick(32'h00000007, 9, b, d);
      finish_chk(wt(e), b, d);

      e = '{8'h35};
      kick(32'h00000005, 9, b, d);
      finish_chk(wt(e), b, d);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule

// File: doc/alu_result_tx_seq.md
Name: alu_result_tx_seq

Overview:
Sequencer that takes the 32-bit ALU result and drives the UART transmitter to send it to the PC as uppercase ASCII hex text, followed by a line terminator.
- Sits between the ALU result bus and the UART TX (tx_start / tx_done / 8-bit data).
- Replaces the raw-byte send done by the command interpreter.
- Owns the TX handshake end-to-end; the interpreter only pulses start and waits for done.

Parameters:
NIBBLES, 8, number of hex digits in the input word; input width = 4*NIBBLES.
TERM_CHAR, 8'h0A, byte sent after the last digit.
SUPPRESS_ZEROS, 1, 1 = skip leading zero digits (at least one digit is always sent); 0 = always send all NIBBLES digits.

Ports:
clk  input  1  clock
reset  input  1  asynchronous active-low reset
start  input  1  request to transmit `result`; sampled only in IDLE
result  input  4*NIBBLES  value to transmit; latched on an accepted start
tx_done  input  1  UART TX byte-complete; level or pulse, rising edge used
tx_start  output  1  one-cycle pulse to UART TX
tx_data  output  8  byte to UART TX
busy  output  1  high from accepted start until the done pulse
done  output  1  one-cycle pulse after the terminator's tx_done

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; tx_start=0, tx_data=8'h00, busy=0, done=0; shift register and digit counter cleared; tx_done edge detector cleared.
- All outputs are registered.
- tx_done handling:
  - Edge-detect against a registered copy; only a 0->1 transition counts.
  - A level held high for many cycles counts once.
  - Edges outside the WAIT states are ignored.
- States:
  - IDLE: busy=0. If start=1, latch result into the shift register, set count=NIBBLES, busy=1. Go to SKIP if SUPPRESS_ZEROS, else SEND.
  - SKIP: one nibble per cycle. If the top nibble is 0 and count>1, shift left 4 and decrement count. Otherwise go to SEND.
  - SEND: tx_data = ASCII of the top nibble (0-9 -> 8'h30-8'h39, A-F -> 8'h41-8'h46); tx_start=1 for this one cycle. Go to WAIT.
  - WAIT: tx_start=0 and tx_data held. On a tx_done edge, shift left 4 and decrement count; if the new count is 0 go to TERM, else SEND.
  - TERM: tx_data=TERM_CHAR, tx_start=1 for one cycle. Go to TWAIT.
  - TWAIT: on a tx_done edge go to DONE.
  - DONE: done=1 for one cycle, busy=0 next cycle. Go to IDLE.
- tx_data is stable from its tx_start pulse until the matching tx_done edge.
- Exactly one tx_start per byte.
- Latency: with no suppressed digits, tx_start rises 2 cycles after the start edge. Each suppressed digit adds 1 cycle.
- start while busy is ignored; no queuing; the latched value is unaffected.
- start and the final done pulse in the same cycle: start is ignored (state is DONE, not IDLE).
- result=0 with SUPPRESS_ZEROS: exactly one '0' (8'h30) is sent.
- Changes on `result` after the latch have no effect.
- Reset mid-transfer: immediate abort to IDLE; no terminator and no done pulse; the next start works normally.

Optional Feature:
Macro ALU_TX_CRLF_EN.
- Defined: an extra state sends 8'h0D (with its own tx_start/tx_done cycle) before TERM_CHAR, so every line ends "\r" + TERM_CHAR.
- Undefined: only TERM_CHAR is sent, and the CR state and its logic are not compiled.

Test Plan:
Bench TX model: tx_done rises 10 cycles after each tx_start and stays high 3 cycles; defaults unless noted.
1. result=32'h0000001F, start pulse -> bytes 8'h31, 8'h46, 8'h0A; one done pulse; busy falls the cycle after done; each byte stable until its tx_done; 3 tx_start pulses total.
2. result=32'h00000000 -> bytes 8'h30, 8'h0A only; with SUPPRESS_ZEROS=0 -> eight 8'h30 then 8'h0A.
3. result=32'hDEADBEEF -> 44 45 41 44 42 45 45 46 0A; first tx_start exactly 2 cycles after the start edge.
4. While busy on 32'h12, pulse start with 32'hFF and hold tx_done high 20 cycles -> output remains 31 32 0A; no extra bytes or skipped digits.
5. Assert reset for 1 cycle during WAIT after the 2nd byte of 32'hABCD -> tx_start=0, busy=0, no 0A, no done; then start with 32'h7 -> 37 0A, done.
6. ALU_TX_CRLF_EN defined, result=32'h5 -> 35 0D 0A, one done pulse.
